pci_cfg_target: RTL and testbench

- Type-0 PCI configuration-space responder: services config read/write requests from the PCI target front end against the 64-dword header.
- Device/Vendor and Class/Revision words come from the CFG constants block: CFG_VENDOR and CFG_CC_REVISION are wired in unchanged.
- Holds the writable header state (command, status, cache line, latency timer, BAR0, interrupt line).
- Exports the decoded enables and the BAR0 base to the address decoder.

---
 rtl/pci_cfg_pkg.sv | 49 ++++
 rtl/pci_cfg_target.sv | 140 ++++++++++++++
 tb/tb_pci_cfg_target.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pci_cfg_pkg.sv
// rtl/pci_cfg_pkg.sv - shared constants, state type and byte-merge helper for the config target
//
// Purpose: register dword indices, Command/Status bit positions, BAR size masks,
//          FSM state encoding and the byte-enable merge used on every write.
// Ports:   none (package).
package pci_cfg_pkg;

   // Header dword indices (AD[7:2])
   localparam logic [5:0] ADDR_VENDOR  = 6'd0;
   localparam logic [5:0] ADDR_CMDSTAT = 6'd1;
   localparam logic [5:0] ADDR_CCREV   = 6'd2;
   localparam logic [5:0] ADDR_MISC    = 6'd3;
   localparam logic [5:0] ADDR_BAR0    = 6'd4;
   localparam logic [5:0] ADDR_INT     = 6'd15;

   // Command register bit positions and the set of bits that hold state
   localparam int          CMD_IO    = 0;
   localparam int          CMD_MEM   = 1;
   localparam int          CMD_BM    = 2;
   localparam logic [15:0] CMD_WMASK = 16'h0147;

   // Status bit positions within the dword (upper half of dword 1)
   localparam int          STAT_STA_BIT  = 27;
   localparam int          STAT_DPE_BIT  = 31;
   localparam logic [1:0]  DEVSEL_MEDIUM = 2'b01;

   // BAR size masks: set bits are the decoded (writable) address bits
   localparam logic [31:0] SIZE16  = 32'hFFFF_FFF0;
   localparam logic [31:0] SIZE256 = 32'hFFFF_FF00;
   localparam logic [31:0] SIZE4K  = 32'hFFFF_F000;
   localparam logic [31:0] SIZE1M  = 32'hFFF0_0000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } cfg_state_t;

   // Replace only the bytes whose enable is set
   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[i*8 +: 8] = be[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/pci_cfg_target.sv
// rtl/pci_cfg_target.sv - Type-0 PCI configuration-space responder
//
// Purpose: services config read/write requests against the 64-dword header and
//          holds the writable header state (command, status, cache line, latency
//          timer, BAR0, interrupt line).
// Ports:
//   CLK, RST_N               clock, asynchronous active-low reset
//   CFG_VENDOR, CFG_CC_REVISION  constant dwords 0 and 2
//   CFG_REQ/WE/ADDR/BE/WDATA request (held until CFG_ACK)
//   CFG_RDATA, CFG_ACK       completion: one-cycle ACK with read data
//   EV_STA, EV_PERR          status event pulses (sticky, RW1C)
//   IO_EN, MEM_EN, BM_EN     decoded command enables
//   BAR0_BASE                BAR0 address with type bits cleared
module pci_cfg_target
   import pci_cfg_pkg::*;
#(
   parameter logic [31:0] BAR0_MASK = SIZE16,
   parameter bit          BAR0_IO   = 1'b1,
   parameter bit          BAR0_PREF = 1'b0,
   parameter logic [7:0]  INT_PIN   = 8'h01
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] CFG_VENDOR,
   input  logic [31:0] CFG_CC_REVISION,
   input  logic        CFG_REQ,
   input  logic        CFG_WE,
   input  logic [5:0]  CFG_ADDR,
   input  logic [3:0]  CFG_BE,
   input  logic [31:0] CFG_WDATA,
   output logic [31:0] CFG_RDATA,
   output logic        CFG_ACK,
   input  logic        EV_STA,
   input  logic        EV_PERR,
   output logic        IO_EN,
   output logic        MEM_EN,
   output logic        BM_EN,
   output logic [31:0] BAR0_BASE
);

   // Read-only low bits of BAR0: I/O indicator, or memory type/prefetch
   localparam logic [31:0] BAR_TYPE = BAR0_IO ? 32'h0000_0001
                                              : {28'h0, BAR0_PREF, 3'b000};

   cfg_state_t  state_q, state_d;
   logic [15:0] cmd_q;
   logic        sta_q, dpe_q;
   logic [7:0]  cls_q, lat_q, int_line_q;
   logic [31:0] bar_q;
   logic [31:0] rdata_q;

   logic        access;
   logic        wr_en;
   logic        sta_clr, dpe_clr;
   logic [31:0] status_word;
   logic [31:0] rd_word;
   logic [31:0] wr_merged;

   assign access = (state_q == ST_IDLE) && CFG_REQ;
   assign wr_en  = access && CFG_WE;

   assign status_word = {dpe_q, 3'b000, sta_q, DEVSEL_MEDIUM, 9'b0, cmd_q};

   // Byte-merged view of the addressed register, used by every write path
   assign wr_merged = be_merge(rd_word, CFG_WDATA, CFG_BE);

   // W1C only counts when the byte holding the bit is enabled
   assign sta_clr = wr_en && (CFG_ADDR == ADDR_CMDSTAT) && CFG_BE[3] && CFG_WDATA[STAT_STA_BIT];
   assign dpe_clr = wr_en && (CFG_ADDR == ADDR_CMDSTAT) && CFG_BE[3] && CFG_WDATA[STAT_DPE_BIT];

   always_comb begin
      rd_word = 32'h0;
      case (CFG_ADDR)
         ADDR_VENDOR:  rd_word = CFG_VENDOR;
         ADDR_CMDSTAT: rd_word = status_word;
         ADDR_CCREV:   rd_word = CFG_CC_REVISION;
         ADDR_MISC:    rd_word = {16'h0000, lat_q, cls_q};
         ADDR_BAR0:    rd_word = bar_q | BAR_TYPE;
         ADDR_INT:     rd_word = {16'h0000, INT_PIN, int_line_q};
         default:      rd_word = 32'h0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      CFG_ACK = 1'b0;
      case (state_q)
         ST_IDLE: if (CFG_REQ) state_d = ST_ACK;
         ST_ACK: begin
            CFG_ACK = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         rdata_q    <= 32'h0;
         cmd_q      <= 16'h0;
         sta_q      <= 1'b0;
         dpe_q      <= 1'b0;
         cls_q      <= 8'h0;
         lat_q      <= 8'h0;
         bar_q      <= 32'h0;
         int_line_q <= 8'h0;
      end else begin
         state_q <= state_d;

         // Set wins over a same-cycle clear
         sta_q <= (sta_q & ~sta_clr) | EV_STA;
         dpe_q <= (dpe_q & ~dpe_clr) | EV_PERR;

         if (access) begin
            rdata_q <= CFG_WE ? 32'h0 : rd_word;
         end

         if (wr_en) begin
            case (CFG_ADDR)
               ADDR_CMDSTAT: cmd_q <= wr_merged[15:0] & CMD_WMASK;
               ADDR_MISC: begin
                  cls_q <= wr_merged[7:0];
                  lat_q <= wr_merged[15:8];
               end
               ADDR_BAR0:    bar_q      <= wr_merged & BAR0_MASK;
               ADDR_INT:     int_line_q <= wr_merged[7:0];
               default: ;
            endcase
         end
      end
   end

   assign CFG_RDATA = rdata_q;
   assign IO_EN     = cmd_q[CMD_IO];
   assign MEM_EN    = cmd_q[CMD_MEM];
   assign BM_EN     = cmd_q[CMD_BM];
   assign BAR0_BASE = bar_q;

endmodule

// File: tb/tb_pci_cfg_target.sv
// tb/tb_pci_cfg_target.sv - directed self-checking bench for pci_cfg_target
module tb_pci_cfg_target;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] cfg_vendor = 32'h0301_10EE;
   logic [31:0] cfg_cc_revision = 32'h0B40_0000;
   logic        cfg_req = 1'b0;
   logic        cfg_we = 1'b0;
   logic [5:0]  cfg_addr = 6'd0;
   logic [3:0]  cfg_be = 4'h0;
   logic [31:0] cfg_wdata = 32'h0;
   logic [31:0] cfg_rdata;
   logic        cfg_ack;
   logic        ev_sta = 1'b0;
   logic        ev_perr = 1'b0;
   logic        io_en, mem_en, bm_en;
   logic [31:0] bar0_base;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   pci_cfg_target dut (
      .CLK             (clk),
      .RST_N           (rst_n),
      .CFG_VENDOR      (cfg_vendor),
      .CFG_CC_REVISION (cfg_cc_revision),
      .CFG_REQ         (cfg_req),
      .CFG_WE          (cfg_we),
      .CFG_ADDR        (cfg_addr),
      .CFG_BE          (cfg_be),
      .CFG_WDATA       (cfg_wdata),
      .CFG_RDATA       (cfg_rdata),
      .CFG_ACK         (cfg_ack),
      .EV_STA          (ev_sta),
      .EV_PERR         (ev_perr),
      .IO_EN           (io_en),
      .MEM_EN          (mem_en),
      .BM_EN           (bm_en),
      .BAR0_BASE       (bar0_base)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One access; returns read data and cycles from request to ACK (99 on timeout)
   task automatic cfg_access(input logic we, input logic [5:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input logic with_sta,
                             output logic [31:0] rdata, output int lat);
      @(negedge clk);
      cfg_req = 1'b1; cfg_we = we; cfg_addr = addr; cfg_be = be; cfg_wdata = wdata;
      ev_sta = with_sta;
      lat = 0;
      rdata = 32'hDEAD_BEEF;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         ev_sta = 1'b0;
         if (cfg_ack) begin
            lat = i;
            rdata = cfg_rdata;
            break;
         end
      end
      if (lat == 0) lat = 99;
      @(negedge clk);
      cfg_req = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [5:0] addr, input logic [31:0] exp);
      logic [31:0] rd; int lat;
      cfg_access(1'b0, addr, 4'hF, 32'h0, 1'b0, rd, lat);
      check_eq({tag, "_lat"}, lat, 1);
      check_eq(tag, rd, exp);
   endtask

   task automatic do_write(input string tag, input logic [5:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic with_sta);
      logic [31:0] rd; int lat;
      cfg_access(1'b1, addr, be, wdata, with_sta, rd, lat);
      check_eq({tag, "_wlat"}, lat, 1);
      check_eq({tag, "_wrdata"}, rd, 32'h0);
   endtask

   initial begin
      int acks;
      #2;
      check_eq("rst_ack", {31'h0, cfg_ack}, 32'h0);
      check_eq("rst_rdata", cfg_rdata, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_read("rd_vendor", 6'd0, 32'h0301_10EE);
      do_read("rd_ccrev", 6'd2, 32'h0B40_0000);
      do_read("rd_cmd_rst", 6'd1, 32'h0200_0000);
      do_read("rd_bar_rst", 6'd4, 32'h0000_0001);

      do_write("bar_ones", 6'd4, 4'hF, 32'hFFFF_FFFF, 1'b0);
      do_read("rd_bar_size", 6'd4, 32'hFFFF_FFF1);
      do_write("bar_1234", 6'd4, 4'hF, 32'h0000_1234, 1'b0);
      do_read("rd_bar_1234", 6'd4, 32'h0000_1231);
      check_eq("bar0_base", bar0_base, 32'h0000_1230);

      do_write("cmd_b0", 6'd1, 4'b0001, 32'h0000_FFFF, 1'b0);
      do_read("rd_cmd_47", 6'd1, 32'h0200_0047);
      check_eq("enables", {29'h0, bm_en, mem_en, io_en}, 32'h7);
      do_write("cmd_b1", 6'd1, 4'b0010, 32'h0000_0100, 1'b0);
      do_read("rd_cmd_147", 6'd1, 32'h0200_0147);

      @(negedge clk); ev_sta = 1'b1; @(negedge clk); ev_sta = 1'b0;
      do_read("rd_sta_set", 6'd1, 32'h0A00_0147);
      do_write("sta_clr", 6'd1, 4'b1000, 32'h0800_0000, 1'b0);
      do_read("rd_sta_clr", 6'd1, 32'h0200_0147);
      @(negedge clk); ev_sta = 1'b1; @(negedge clk); ev_sta = 1'b0;
      do_write("sta_race", 6'd1, 4'b1000, 32'h0800_0000, 1'b1);
      do_read("rd_sta_race", 6'd1, 32'h0A00_0147);
      do_write("sta_clr_be", 6'd1, 4'b0111, 32'h0800_0000, 1'b0);
      do_read("rd_sta_be_off", 6'd1, 32'h0A00_0000);

      @(negedge clk); ev_perr = 1'b1; @(negedge clk); ev_perr = 1'b0;
      do_read("rd_dpe_set", 6'd1, 32'h8A00_0000);
      do_write("dpe_clr", 6'd1, 4'b1000, 32'h8800_0000, 1'b0);
      do_read("rd_dpe_clr", 6'd1, 32'h0200_0000);

      do_write("misc", 6'd3, 4'hF, 32'hFFFF_2010, 1'b0);
      do_read("rd_misc", 6'd3, 32'h0000_2010);
      do_read("rd_int_rst", 6'd15, 32'h0000_0100);
      do_write("int_line", 6'd15, 4'b0001, 32'h0000_000B, 1'b0);
      do_read("rd_int", 6'd15, 32'h0000_010B);
      do_write("bar1", 6'd5, 4'hF, 32'hFFFF_FFFF, 1'b0);
      do_read("rd_bar1", 6'd5, 32'h0);
      do_read("rd_dw20", 6'd20, 32'h0);

      // Set enables again, then reset while ACK is high
      do_write("cmd_all", 6'd1, 4'hF, 32'h0000_0007, 1'b0);
      @(negedge clk);
      cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 6'd4; cfg_be = 4'hF;
      @(posedge clk); #1;
      check_eq("mid_ack_hi", {31'h0, cfg_ack}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_ack_lo", {31'h0, cfg_ack}, 32'h0);
      check_eq("mid_rdata", cfg_rdata, 32'h0);
      check_eq("mid_en", {29'h0, bm_en, mem_en, io_en}, 32'h0);
      check_eq("mid_bar", bar0_base, 32'h0);
      cfg_req = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      do_read("rd_cmd_after", 6'd1, 32'h0200_0000);
      do_read("rd_bar_after", 6'd4, 32'h0000_0001);
      do_read("rd_misc_after", 6'd3, 32'h0);
      do_read("rd_int_after", 6'd15, 32'h0000_0100);

      // Held request: one ACK every two clocks
      @(negedge clk);
      cfg_req = 1'b1; cfg_addr = 6'd0;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (cfg_ack) acks++;
      end
      @(negedge clk); cfg_req = 1'b0;
      check_eq("b2b_acks", acks, 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
